// File: rtl/tft_timing_controller.sv
// Raster timing generator for a TFT panel: scans h/v counters through active, porch and
// sync regions, drives pixel coordinates, and delays panel strobes by the framebuffer read latency.
module tft_timing_controller #(
    parameter int H_ACTIVE    = 480,
    parameter int H_FP        = 2,
    parameter int H_SYNC      = 41,
    parameter int H_BP        = 2,
    parameter int V_ACTIVE    = 272,
    parameter int V_FP        = 2,
    parameter int V_SYNC      = 10,
    parameter int V_BP        = 2,
    parameter int RAM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    output logic [8:0]  x,
    output logic [8:0]  y,
    input  logic [15:0] rd_data,
    output logic [15:0] tft_rgb,
    output logic        tft_de,
    output logic        tft_hsync_n,
    output logic        tft_vsync_n,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT_END  = 9'(V_ACTIVE - 1);
    localparam logic [8:0] V_FP_END   = 9'(V_ACTIVE + V_FP - 1);
    localparam logic [8:0] V_SYNC_END = 9'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 512 || H_ACTIVE > 512 || V_ACTIVE > 512) begin : g_bad_geometry
            $error("tft_timing_controller: raster geometry exceeds counter width");
        end
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
            $error("tft_timing_controller: porch and sync regions must be at least one slot");
        end
        if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
            $error("tft_timing_controller: RAM_LATENCY must be 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t    r_h_state;
    v_state_t    r_v_state;
    logic [9:0]  r_hcount;
    logic [8:0]  r_vcount;
    logic [8:0]  r_x;
    logic [8:0]  r_y;
    logic        r_frame_start;
    logic [15:0] r_rgb;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [9:0]  w_h_next;
    logic [8:0]  w_v_next;

    assign w_h_wrap = (r_hcount == H_LAST);
    assign w_v_wrap = (r_vcount == V_LAST);
    assign w_h_next = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
    assign w_v_next = w_v_wrap ? 9'd0 : r_vcount + 9'd1;

    // Coordinates are computed from the next counter value so x/y always match the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_state     <= HS_ACT;
            r_v_state     <= VS_ACT;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else if (ena) begin
            r_hcount      <= w_h_next;
            r_frame_start <= w_h_wrap && w_v_wrap;

            case (r_h_state)
                HS_ACT: begin
                    if (r_hcount == H_ACT_END) begin
                        r_h_state <= HS_FP;
                        r_x       <= '0;
                    end else begin
                        r_x <= w_h_next[8:0];
                    end
                end
                HS_FP:   if (r_hcount == H_FP_END)   r_h_state <= HS_SYNC;
                HS_SYNC: if (r_hcount == H_SYNC_END) r_h_state <= HS_BP;
                HS_BP: begin
                    if (w_h_wrap) begin
                        r_h_state <= HS_ACT;
                        r_x       <= '0;
                    end
                end
                default: r_h_state <= HS_ACT;
            endcase

            // The vertical machine only moves on the line wrap.
            if (w_h_wrap) begin
                r_vcount <= w_v_next;
                case (r_v_state)
                    VS_ACT: begin
                        if (r_vcount == V_ACT_END) begin
                            r_v_state <= VS_FP;
                            r_y       <= '0;
                        end else begin
                            r_y <= w_v_next[8:0];
                        end
                    end
                    VS_FP:   if (r_vcount == V_FP_END)   r_v_state <= VS_SYNC;
                    VS_SYNC: if (r_vcount == V_SYNC_END) r_v_state <= VS_BP;
                    VS_BP: begin
                        if (w_v_wrap) begin
                            r_v_state <= VS_ACT;
                            r_y       <= '0;
                        end
                    end
                    default: r_v_state <= VS_ACT;
                endcase
            end
        end
    end

    logic [RAM_LATENCY:0] w_de_chain;
    logic [RAM_LATENCY:0] w_hs_chain;
    logic [RAM_LATENCY:0] w_vs_chain;

    assign w_de_chain[0] = (r_h_state == HS_ACT) && (r_v_state == VS_ACT);
    assign w_hs_chain[0] = (r_h_state != HS_SYNC);
    assign w_vs_chain[0] = (r_v_state != VS_SYNC);

    // Strobe alignment pipeline; reset forces every stage inactive so no stale sync leaks out.
    genvar gi;
    generate
        for (gi = 0; gi < RAM_LATENCY; gi++) begin : g_stage
            logic r_de;
            logic r_hs_n;
            logic r_vs_n;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_de   <= 1'b0;
                    r_hs_n <= 1'b1;
                    r_vs_n <= 1'b1;
                end else if (ena) begin
                    r_de   <= w_de_chain[gi];
                    r_hs_n <= w_hs_chain[gi];
                    r_vs_n <= w_vs_chain[gi];
                end
            end
            assign w_de_chain[gi+1] = r_de;
            assign w_hs_chain[gi+1] = r_hs_n;
            assign w_vs_chain[gi+1] = r_vs_n;
        end
    endgenerate

    // Pixel data is captured on the same edge the final de stage loads, keeping it aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (ena) begin
            r_rgb <= w_de_chain[RAM_LATENCY-1] ? rd_data : 16'h0000;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;
    assign tft_rgb     = r_rgb;
    assign tft_de      = w_de_chain[RAM_LATENCY];
    assign tft_hsync_n = w_hs_chain[RAM_LATENCY];
    assign tft_vsync_n = w_vs_chain[RAM_LATENCY];

endmodule

// File: tb/tb_tft_timing_controller.sv
// Scoreboard bench for tft_timing_controller: the driver pushes the expected outputs for every
// clock edge, computed from the raster position, and a monitor pops and compares after each edge.
module tb_tft_timing_controller;
    // Full horizontal geometry; a short frame keeps whole-frame runs within the cycle budget.
    localparam int HA  = 480;
    localparam int HFP = 2;
    localparam int HS  = 41;
    localparam int HBP = 2;
    localparam int VA  = 6;
    localparam int VFP = 2;
    localparam int VS  = 3;
    localparam int VBP = 2;
    localparam int LAT = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] rd_data;
    logic [15:0] tft_rgb;
    logic        tft_de;
    logic        tft_hsync_n;
    logic        tft_vsync_n;
    logic        frame_start;

    always #5 clk = ~clk;

    tft_timing_controller #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RAM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .x(x),
        .y(y),
        .rd_data(rd_data),
        .tft_rgb(tft_rgb),
        .tft_de(tft_de),
        .tft_hsync_n(tft_hsync_n),
        .tft_vsync_n(tft_vsync_n),
        .frame_start(frame_start)
    );

    // Framebuffer model: block RAM with registered read holding {x,y} at each address; the
    // address is x/y and the word is sampled by the DUT on the LAT-th ena edge after x/y.
    logic [15:0] ram_q;
    always @(posedge clk or posedge rst) begin
        if (rst) ram_q <= 16'h0;
        else if (ena) ram_q <= {x[7:0], y[7:0]};
    end
    assign rd_data = ram_q;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic        de;
        logic        hs_n;
        logic        vs_n;
        logic [15:0] rgb;
        logic        fs;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n           = 0;
    int   max_x       = 0;
    int   max_y       = 0;

    // Expected outputs after k ena edges since reset release, from raster arithmetic alone.
    function automatic obs_t model(input int k);
        obs_t o;
        int h, v, q, hq, vq;
        h    = k % HT;
        v    = (k / HT) % VT;
        o.x  = (h < HA) ? 9'(h) : 9'd0;
        o.y  = (v < VA) ? 9'(v) : 9'd0;
        o.fs = (k > 0) && (k % FT == 0);
        if (k < LAT) begin
            o.de   = 1'b0;
            o.hs_n = 1'b1;
            o.vs_n = 1'b1;
            o.rgb  = 16'h0;
        end else begin
            q      = k - LAT;
            hq     = q % HT;
            vq     = (q / HT) % VT;
            o.de   = (hq < HA) && (vq < VA);
            o.hs_n = !(hq >= HA + HFP && hq < HA + HFP + HS);
            o.vs_n = !(vq >= VA + VFP && vq < VA + VFP + VS);
            o.rgb  = o.de ? {8'(hq), 8'(vq)} : 16'h0;
        end
        return o;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        ena = e;
        if (r) n = 0;
        else if (e) n++;
        exp_q.push_back(model(n));
    endtask

    // Monitor: one expected entry per clock edge once the driver has started.
    initial begin
        obs_t e_o, a_o;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e_o      = exp_q.pop_front();
                a_o.x    = x;
                a_o.y    = y;
                a_o.de   = tft_de;
                a_o.hs_n = tft_hsync_n;
                a_o.vs_n = tft_vsync_n;
                a_o.rgb  = tft_rgb;
                a_o.fs   = frame_start;
                vectors++;
                if (a_o !== e_o) begin
                    miscompares++;
                    $display("FAIL scan vector %0d: got x=%0d y=%0d de=%b hs_n=%b vs_n=%b rgb=%h fs=%b, expected x=%0d y=%0d de=%b hs_n=%b vs_n=%b rgb=%h fs=%b",
                             vectors, a_o.x, a_o.y, a_o.de, a_o.hs_n, a_o.vs_n, a_o.rgb, a_o.fs,
                             e_o.x, e_o.y, e_o.de, e_o.hs_n, e_o.vs_n, e_o.rgb, e_o.fs);
                end
                if (int'(x) > max_x) max_x = int'(x);
                if (int'(y) > max_y) max_y = int'(y);
                if (frame_start && !e_o.fs)
                    $display("frame_start seen unexpectedly at vector %0d", vectors);
                else if (e_o.fs && frame_start && ena)
                    $display("frame_start at vector %0d", vectors);
            end
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int target;

        // Reset held with ena high: outputs must stay at reset values.
        repeat (5) step(1'b1, 1'b1);
        $display("phase reset-hold: %0d vectors", vectors);

        // Free-running scan, two full frames plus a few lines.
        repeat (2 * FT + 50) step(1'b0, 1'b1);
        $display("phase ena-high: %0d vectors, n=%0d", vectors, n);

        // Sparse enable: same per-ena-cycle sequence, outputs hold in between.
        target = n + 8000;
        for (int i = 0; i < 30000 && n < target; i++)
            step(1'b0, ($urandom_range(0, 2) == 0));
        $display("phase ena-gated: %0d vectors, n=%0d", vectors, n);

        // Run to hcount=500 inside a vsync line, then reset mid-pulse.
        for (int i = 0; i < FT + 10; i++) begin
            if ((n % HT == 500) && ((n / HT) % VT == VA + VFP + 1)) break;
            step(1'b0, 1'b1);
        end
        check("sync active before reset", int'({tft_hsync_n, tft_vsync_n}), 0);
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;
        n   = 0;
        exp_q.push_back(model(0));
        #1;
        check("async reset de", int'(tft_de), 0);
        check("async reset hsync_n", int'(tft_hsync_n), 1);
        check("async reset vsync_n", int'(tft_vsync_n), 1);
        check("async reset x", int'(x), 0);
        repeat (2) step(1'b1, 1'b1);
        $display("phase mid-frame reset: %0d vectors", vectors);

        // A clean frame follows; frame_start must first appear FT ena cycles after release.
        repeat (FT + 100) step(1'b0, 1'b1);
        $display("phase post-reset frame: %0d vectors", vectors);

        @(posedge clk);
        #3;
        check("scoreboard drained", exp_q.size(), 0);
        check("max x", max_x, HA - 1);
        check("max y", max_y, VA - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
